// File: rtl/zion_lsu_req_ctrl.sv
// LSU request/response controller: aligns requests to bus words with byte strobes, tracks loads, extends returned data.
// Request issue 1 cycle after accept, held until busReqRdy; load data 1 cycle after busRspVld (2 with ZION_LSU_RSP_PIPE_EN).
module zion_lsu_req_ctrl #(
  parameter int RV64  = 0,
  parameter int DEPTH = 4,
  localparam int DW   = (RV64 != 0) ? 64 : 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cpuReqVld,
  output logic            cpuReqRdy,
  input  logic            memEn,
  input  logic            load,
  input  logic            store,
  input  logic            unsignedFlg,
  input  logic [1:0]      memWidth,
  input  logic [DW-1:0]   memAddr,
  input  logic [DW-1:0]   storeDat,
  output logic            busReqVld,
  input  logic            busReqRdy,
  output logic            busReqWr,
  output logic [DW-1:0]   busReqAddr,
  output logic [DW/8-1:0] busReqStrb,
  output logic [DW-1:0]   busReqDat,
  input  logic            busRspVld,
  input  logic [DW-1:0]   busRspDat,
  output logic            ldDatVld,
  output logic [DW-1:0]   ldDat,
  output logic            excVld,
  output logic            busy
);

  localparam int BW = DW / 8;
  localparam int OB = $clog2(BW);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [OB-1:0] off;
    logic [1:0]    width;
    logic          uns;
  } trkEnt_t;

  logic          accept;
  logic          illegal;
  logic          misalign;
  logic          legal;
  logic          fault;
  logic          push;
  logic          pop;
  logic [OB-1:0] off;
  logic [OB-1:0] alignMask;
  logic [BW-1:0] sizeMask;
  logic [CW-1:0] count;
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  trkEnt_t       trkMem [DEPTH];
  trkEnt_t       head;
  logic [DW-1:0] shifted;
  logic [DW-1:0] ext;
  logic          sgn;

  // ---------------------------------------------------------------- request decode
  assign off = memAddr[OB-1:0];

  always_comb begin
    sizeMask  = '0;
    alignMask = '0;
    for (int i = 0; i < BW; i++) sizeMask[i] = (i < (1 << memWidth));
    for (int i = 0; i < OB; i++) alignMask[i] = (i < int'(memWidth));
  end

  assign illegal   = (load == store) || ((memWidth == 2'd3) && (RV64 == 0));
  assign misalign  = |(off & alignMask);
  assign legal     = memEn && !illegal && !misalign;
  assign fault     = memEn && (illegal || misalign);
  assign cpuReqRdy = (!busReqVld || busReqRdy) && (count < CW'(DEPTH));
  assign accept    = cpuReqVld && cpuReqRdy;
  assign push      = accept && legal && load;
  assign pop       = busRspVld && (count != '0);
  assign busy      = (count != '0) || busReqVld;

  // ---------------------------------------------------------------- bus request register
  always_ff @(posedge clk) begin
    if (rst) begin
      busReqVld  <= 1'b0;
      busReqWr   <= 1'b0;
      busReqAddr <= '0;
      busReqStrb <= '0;
      busReqDat  <= '0;
      excVld     <= 1'b0;
    end else begin
      if (accept && legal) begin
        busReqVld  <= 1'b1;
        busReqWr   <= store;
        busReqAddr <= {memAddr[DW-1:OB], {OB{1'b0}}};
        busReqStrb <= sizeMask << off;
        busReqDat  <= storeDat << {off, 3'b000};
      end else if (busReqRdy) begin
        busReqVld  <= 1'b0;
      end
      excVld <= accept && fault;
    end
  end

  // ---------------------------------------------------------------- outstanding-load tracker
  // Entry is captured at accept time; the response cannot precede the bus issue a cycle later.
  always_ff @(posedge clk) begin
    if (push) trkMem[wrPtr] <= '{off: off, width: memWidth, uns: unsignedFlg};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop)  rdPtr <= rdPtr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------- load data alignment / extension
  assign head    = trkMem[rdPtr];
  assign shifted = busRspDat >> {head.off, 3'b000};

  always_comb begin
    case (head.width)
      2'd0:    sgn = shifted[7];
      2'd1:    sgn = shifted[15];
      2'd2:    sgn = shifted[31];
      default: sgn = shifted[DW-1];
    endcase
    sgn = sgn && !head.uns;
    ext = '0;
    for (int i = 0; i < DW; i++) ext[i] = (i < (8 << head.width)) ? shifted[i] : sgn;
  end

`ifdef ZION_LSU_RSP_PIPE_EN
  logic          rspVld1;
  logic [DW-1:0] rspDat1;

  always_ff @(posedge clk) begin
    if (rst) begin
      rspVld1  <= 1'b0;
      rspDat1  <= '0;
      ldDatVld <= 1'b0;
      ldDat    <= '0;
    end else begin
      rspVld1  <= pop;
      ldDatVld <= rspVld1;
      if (pop)     rspDat1 <= ext;
      if (rspVld1) ldDat   <= rspDat1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      ldDatVld <= 1'b0;
      ldDat    <= '0;
    end else begin
      ldDatVld <= pop;
      if (pop) ldDat <= ext;
    end
  end
`endif

endmodule

// File: tb/tb_zion_lsu_req_ctrl.sv
// Directed bench for zion_lsu_req_ctrl (RV64=0, DEPTH=4); load data checked through an in-order expectation queue.
`timescale 1ns/1ps
module tb_zion_lsu_req_ctrl;

`ifdef ZION_LSU_RSP_PIPE_EN
  localparam int RSP_LAT = 2;
`else
  localparam int RSP_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cpuReqVld;
  logic        cpuReqRdy;
  logic        memEn;
  logic        load;
  logic        store;
  logic        unsignedFlg;
  logic [1:0]  memWidth;
  logic [31:0] memAddr;
  logic [31:0] storeDat;
  logic        busReqVld;
  logic        busReqRdy;
  logic        busReqWr;
  logic [31:0] busReqAddr;
  logic [3:0]  busReqStrb;
  logic [31:0] busReqDat;
  logic        busRspVld;
  logic [31:0] busRspDat;
  logic        ldDatVld;
  logic [31:0] ldDat;
  logic        excVld;
  logic        busy;

  int          nChecks = 0;
  int          nPass   = 0;
  logic [31:0] expQ[$];

  zion_lsu_req_ctrl #(.RV64(0), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cpuReqVld(cpuReqVld), .cpuReqRdy(cpuReqRdy),
    .memEn(memEn), .load(load), .store(store), .unsignedFlg(unsignedFlg),
    .memWidth(memWidth), .memAddr(memAddr), .storeDat(storeDat),
    .busReqVld(busReqVld), .busReqRdy(busReqRdy), .busReqWr(busReqWr),
    .busReqAddr(busReqAddr), .busReqStrb(busReqStrb), .busReqDat(busReqDat),
    .busRspVld(busRspVld), .busRspDat(busRspDat),
    .ldDatVld(ldDatVld), .ldDat(ldDat), .excVld(excVld), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic en, input logic ld, input logic st, input logic uns,
                     input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
    cpuReqVld   = 1'b1;
    memEn       = en;
    load        = ld;
    store       = st;
    unsignedFlg = uns;
    memWidth    = w;
    memAddr     = a;
    storeDat    = d;
  endtask

  task automatic idle();
    cpuReqVld = 1'b0;
  endtask

  task automatic rsp(input logic [31:0] d, input logic [31:0] exp);
    busRspVld = 1'b1;
    busRspDat = d;
    expQ.push_back(exp);
  endtask

  // Single LH at 0x1002 with response 0x80FF1234; measures response latency.
  task automatic lhCase(input logic uns, input logic [31:0] exp);
    int lat;
    req(1'b1, 1'b1, 1'b0, uns, 2'd1, 32'h1002, 32'h0);
    step();
    idle();
    check("lhStrb", busReqStrb, 4'hC);
    check("lhWr", busReqWr, 1'b0);
    check("lhBusy", busy, 1'b1);
    step();
    rsp(32'h80FF1234, exp);
    step();
    busRspVld = 1'b0;
    lat = 1;
    while (!ldDatVld && lat < 5) begin
      step();
      lat++;
    end
    check("lhLat", lat, RSP_LAT);
    check("lhDat", ldDat, exp);
    step();
    step();
  endtask

  // Every ldDatVld must match the next expected load value, in order.
  always @(negedge clk) begin
    if (!rst && ldDatVld) begin
      if (expQ.size() == 0) check("ldUnexpected", ldDatVld, 1'b0);
      else check("ldDatQ", ldDat, expQ.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen;
    rst = 1'b1; cpuReqVld = 1'b0; memEn = 1'b0; load = 1'b0; store = 1'b0;
    unsignedFlg = 1'b0; memWidth = 2'd0; memAddr = '0; storeDat = '0;
    busReqRdy = 1'b1; busRspVld = 1'b0; busRspDat = '0;
    step();
    step();
    rst = 1'b0;
    check("rstBusVld", busReqVld, 1'b0);
    check("rstLdVld", ldDatVld, 1'b0);
    check("rstExc", excVld, 1'b0);
    check("rstBusy", busy, 1'b0);
    check("rstStrb", busReqStrb, 4'h0);
    check("rstAddr", busReqAddr, 32'h0);
    check("rstDat", busReqDat, 32'h0);
    check("rstWr", busReqWr, 1'b0);
    check("rstLdDat", ldDat, 32'h0);
    check("rstRdy", cpuReqRdy, 1'b1);

    // SW 0x1000
    req(1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 32'h1000, 32'h11223344);
    step();
    idle();
    check("swVld", busReqVld, 1'b1);
    check("swStrb", busReqStrb, 4'hF);
    check("swAddr", busReqAddr, 32'h1000);
    check("swWr", busReqWr, 1'b1);
    check("swDat", busReqDat, 32'h11223344);
    check("swExc", excVld, 1'b0);
    step();
    check("swDrop", busReqVld, 1'b0);
    check("swNoBusy", busy, 1'b0);

    // SB 0x1003
    req(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h1003, 32'h000000A5);
    step();
    idle();
    check("sbStrb", busReqStrb, 4'h8);
    check("sbDat", busReqDat, 32'hA5000000);
    check("sbAddr", busReqAddr, 32'h1000);
    step();

    lhCase(1'b0, 32'hFFFF80FF);
    lhCase(1'b1, 32'h000080FF);

    // misaligned LW
    req(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 32'h1001, 32'h0);
    step();
    idle();
    check("misExc", excVld, 1'b1);
    check("misNoReq", busReqVld, 1'b0);
    step();
    check("misPulse", excVld, 1'b0);

    // D width on RV32
    req(1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 32'h1000, 32'h0);
    step();
    idle();
    check("dwExc", excVld, 1'b1);
    check("dwNoReq", busReqVld, 1'b0);
    step();

    // load and store both set
    req(1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 32'h1000, 32'h0);
    step();
    idle();
    check("ldStExc", excVld, 1'b1);
    step();

    // memEn=0 is a no-op even if misaligned
    req(1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 32'h1001, 32'h0);
    step();
    idle();
    check("noEnExc", excVld, 1'b0);
    check("noEnReq", busReqVld, 1'b0);
    check("noEnBusy", busy, 1'b0);

    // fill tracker with four loads
    req(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'h2000, 32'h0);
    step();
    check("f0Strb", busReqStrb, 4'h1);
    req(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'h2001, 32'h0);
    step();
    check("f1Strb", busReqStrb, 4'h2);
    req(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 32'h2002, 32'h0);
    step();
    check("f2Strb", busReqStrb, 4'hC);
    req(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 32'h2004, 32'h0);
    step();
    check("f3Strb", busReqStrb, 4'hF);
    check("fullRdy", cpuReqRdy, 1'b0);
    req(1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 32'h2003, 32'h0);
    step();
    check("fullNoIssue", busReqVld, 1'b0);
    check("fullRdyHeld", cpuReqRdy, 1'b0);
    rsp(32'h000000F0, 32'hFFFFFFF0);
    step();
    check("popRdy", cpuReqRdy, 1'b1);
    rsp(32'h00007F00, 32'h0000007F);
    step();
    check("ppIssue", busReqVld, 1'b1);
    check("ppStrb", busReqStrb, 4'h8);
    req(1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 32'h2006, 32'h0);
    check("ppRdy", cpuReqRdy, 1'b1);
    busRspVld = 1'b0;
    step();
    idle();
    check("refullRdy", cpuReqRdy, 1'b0);
    check("refullStrb", busReqStrb, 4'hC);
    rsp(32'h80000000, 32'hFFFF8000);
    step();
    rsp(32'hDEADBEEF, 32'hDEADBEEF);
    step();
    rsp(32'hA5000000, 32'h000000A5);
    step();
    rsp(32'hBEEF0000, 32'h0000BEEF);
    step();
    busRspVld = 1'b0;
    repeat (3) step();
    check("drain", expQ.size(), 0);
    check("drainBusy", busy, 1'b0);

    // backpressure hold
    busReqRdy = 1'b0;
    req(1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 32'h3002, 32'h0000BEEF);
    step();
    req(1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 32'h3004, 32'h55667788);
    for (int i = 0; i < 3; i++) begin
      check("holdVld", busReqVld, 1'b1);
      check("holdDat", busReqDat, 32'hBEEF0000);
      check("holdStrb", busReqStrb, 4'hC);
      check("holdAddr", busReqAddr, 32'h3000);
      check("holdRdy", cpuReqRdy, 1'b0);
      step();
    end
    busReqRdy = 1'b1;
    #1;
    check("relRdy", cpuReqRdy, 1'b1);
    step();
    idle();
    check("relAddr", busReqAddr, 32'h3004);
    check("relStrb", busReqStrb, 4'hF);
    check("relDat", busReqDat, 32'h55667788);
    step();
    check("relDrop", busReqVld, 1'b0);

    // reset with two loads outstanding
    req(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 32'h4000, 32'h0);
    step();
    req(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 32'h4004, 32'h0);
    step();
    idle();
    step();
    check("preRstBusy", busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("postRstBusy", busy, 1'b0);
    check("postRstReq", busReqVld, 1'b0);
    check("postRstRdy", cpuReqRdy, 1'b1);
    busRspVld = 1'b1;
    busRspDat = 32'h12345678;
    step();
    busRspVld = 1'b0;
    seen = 0;
    repeat (3) begin
      if (ldDatVld) seen++;
      step();
    end
    check("rstNoLd", seen, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
